// File: rtl/segasys1_pkg.sv
// rtl/segasys1_pkg.sv - shared constants and helpers for System 1 type-2 program crypto
package segasys1_pkg;

  localparam logic [24:0] TBL_BASE = 25'h2C100;
  localparam int          MAX_SWP  = 23;

  // {A,B,C,D}: ciphertext bit positions receiving y[6], y[4], y[2], y[0]
  localparam logic [0:23][11:0] SWP_PERM = '{
    {3'd6, 3'd4, 3'd2, 3'd0}, {3'd4, 3'd6, 3'd2, 3'd0},
    {3'd2, 3'd4, 3'd6, 3'd0}, {3'd0, 3'd4, 3'd2, 3'd6},
    {3'd6, 3'd2, 3'd4, 3'd0}, {3'd6, 3'd0, 3'd2, 3'd4},
    {3'd6, 3'd4, 3'd0, 3'd2}, {3'd2, 3'd6, 3'd4, 3'd0},
    {3'd4, 3'd2, 3'd6, 3'd0}, {3'd4, 3'd6, 3'd0, 3'd2},
    {3'd6, 3'd0, 3'd4, 3'd2}, {3'd0, 3'd6, 3'd4, 3'd2},
    {3'd4, 3'd0, 3'd6, 3'd2}, {3'd0, 3'd4, 3'd6, 3'd2},
    {3'd6, 3'd2, 3'd0, 3'd4}, {3'd2, 3'd6, 3'd0, 3'd4},
    {3'd0, 3'd6, 3'd2, 3'd4}, {3'd2, 3'd0, 3'd6, 3'd4},
    {3'd0, 3'd2, 3'd6, 3'd4}, {3'd4, 3'd2, 3'd0, 3'd6},
    {3'd2, 3'd4, 3'd0, 3'd6}, {3'd4, 3'd0, 3'd2, 3'd6},
    {3'd2, 3'd0, 3'd4, 3'd6}, {3'd0, 3'd2, 3'd4, 3'd6}
  };

  function automatic logic [6:0] build_ix(input logic m1, input logic [14:0] ad);
    return {ad[14], ad[12], ad[9], ad[6], ad[3], ad[0], ~m1};
  endfunction

endpackage

// File: rtl/segasys1_encbswp.sv
// rtl/segasys1_encbswp.sv - inverse even-bit permutation for the type-2 encryptor
module segasys1_encbswp
  import segasys1_pkg::*;
#(
  parameter int MAX_CODE = MAX_SWP
) (
  input  logic [7:0] code,
  input  logic [7:0] y,
  output logic [7:0] c,
  output logic       err
);

  logic [11:0] perm;

  always_comb begin
    err  = int'(code) > MAX_CODE;
    perm = SWP_PERM[err ? 5'd0 : code[4:0]];
    c    = {y[7], 1'b0, y[5], 1'b0, y[3], 1'b0, y[1], 1'b0};
    c[perm[11:9]] = y[6];
    c[perm[8:6]]  = y[4];
    c[perm[5:3]]  = y[2];
    c[perm[2:0]]  = y[0];
    if (err) c = 8'h00;
  end

endmodule

// File: rtl/segasys1_prgenc.sv
// rtl/segasys1_prgenc.sv - type-2 program ROM encryptor, 2-stage pipeline with downloadable tables
module segasys1_prgenc #(
  parameter logic [24:0] TBL_BASE = segasys1_pkg::TBL_BASE,
  parameter int          MAX_SWP  = segasys1_pkg::MAX_SWP
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [24:0] ROMAD,
  input  logic [7:0]  ROMDT,
  input  logic        ROMEN,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_m1,
  input  logic [14:0] in_ad,
  input  logic [7:0]  in_dt,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [14:0] out_ad,
  output logic [7:0]  out_dt,
  output logic        out_err,
  output logic        tbl_loaded
);
  import segasys1_pkg::*;

  logic        adv, accept;
  logic        xor_we, swp_we, tbl_we;
  logic [6:0]  rix;
  logic [7:0]  xor_mem [128];
  logic [7:0]  swp_mem [128];
  logic [7:0]  xd, sd;
  logic        s1_valid;
  logic [14:0] s1_ad;
  logic [7:0]  s1_dt;
  logic [7:0]  y, c;
  logic        err;
  logic [8:0]  cnt;

  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv & ~ROMEN;
  assign accept   = in_valid & in_ready;
  assign xor_we   = ROMEN & (ROMAD[24:7] == TBL_BASE[24:7]);
  assign swp_we   = ROMEN & (ROMAD[24:7] == TBL_BASE[24:7] + 18'd1);
  assign tbl_we   = xor_we | swp_we;
  assign rix      = build_ix(in_m1, in_ad);

  // Reads return the pre-write contents, and hold while the pipeline is stalled
  always_ff @(posedge clk) begin
    if (xor_we) xor_mem[ROMAD[6:0]] <= ROMDT;
    if (swp_we) swp_mem[ROMAD[6:0]] <= ROMDT;
    if (adv) begin
      xd <= xor_mem[rix];
      sd <= swp_mem[rix];
    end
  end

  assign y = s1_dt ^ xd;

  segasys1_encbswp #(.MAX_CODE(MAX_SWP)) u_bswp (
    .code (sd),
    .y    (y),
    .c    (c),
    .err  (err)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid  <= 1'b0;
      s1_ad     <= '0;
      s1_dt     <= '0;
      out_valid <= 1'b0;
      out_ad    <= '0;
      out_dt    <= '0;
      out_err   <= 1'b0;
    end else if (adv) begin
      s1_valid  <= accept;
      s1_ad     <= in_ad;
      s1_dt     <= in_dt;
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_ad  <= s1_ad;
        out_dt  <= c;
        out_err <= err;
      end
    end
  end

  // A write below the table region marks the start of a fresh download
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (ROMEN && (ROMAD < TBL_BASE)) begin
      cnt <= '0;
    end else if (tbl_we && (cnt != 9'd256)) begin
      cnt <= cnt + 9'd1;
    end
  end

  assign tbl_loaded = (cnt == 9'd256);

endmodule

// File: tb/tb_segasys1_prgenc.sv
// tb/tb_segasys1_prgenc.sv - self-checking bench for segasys1_prgenc
module tb_segasys1_prgenc;

  logic        clk = 1'b0;
  logic        reset;
  logic [24:0] ROMAD;
  logic [7:0]  ROMDT;
  logic        ROMEN;
  logic        in_valid, in_ready, in_m1;
  logic [14:0] in_ad;
  logic [7:0]  in_dt;
  logic        out_valid, out_ready, out_err, tbl_loaded;
  logic [14:0] out_ad;
  logic [7:0]  out_dt;

  always #5 clk = ~clk;

  segasys1_prgenc dut (
    .clk(clk), .reset(reset), .ROMAD(ROMAD), .ROMDT(ROMDT), .ROMEN(ROMEN),
    .in_valid(in_valid), .in_ready(in_ready), .in_m1(in_m1), .in_ad(in_ad), .in_dt(in_dt),
    .out_valid(out_valid), .out_ready(out_ready), .out_ad(out_ad), .out_dt(out_dt),
    .out_err(out_err), .tbl_loaded(tbl_loaded)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] xm [128];
  logic [7:0] sm [128];

  // Decryptor's view: plain[6,4,2,0] come from cipher bits A,B,C,D
  int swp_ref [0:23][0:3] = '{
    '{6,4,2,0}, '{4,6,2,0}, '{2,4,6,0}, '{0,4,2,6}, '{6,2,4,0}, '{6,0,2,4},
    '{6,4,0,2}, '{2,6,4,0}, '{4,2,6,0}, '{4,6,0,2}, '{6,0,4,2}, '{0,6,4,2},
    '{4,0,6,2}, '{0,4,6,2}, '{6,2,0,4}, '{2,6,0,4}, '{0,6,2,4}, '{2,0,6,4},
    '{0,2,6,4}, '{4,2,0,6}, '{2,4,0,6}, '{4,0,2,6}, '{2,0,4,6}, '{0,2,4,6}
  };

  typedef struct packed {
    logic        m1;
    logic [14:0] ad;
    logic [7:0]  pt;
    logic [7:0]  dt;
    logic        err;
  } exp_t;

  exp_t sb[$];
  logic accepted;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] mix(input logic m1, input logic [14:0] ad);
    return {ad[14], ad[12], ad[9], ad[6], ad[3], ad[0], ~m1};
  endfunction

  function automatic logic [7:0] ref_dec(input logic m1, input logic [14:0] ad, input logic [7:0] c);
    logic [6:0] ix;
    logic [7:0] y;
    int s;
    ix = mix(m1, ad);
    s  = int'(sm[ix]);
    y  = c;
    y[6] = c[3'(swp_ref[s][0])];
    y[4] = c[3'(swp_ref[s][1])];
    y[2] = c[3'(swp_ref[s][2])];
    y[0] = c[3'(swp_ref[s][3])];
    return y ^ xm[ix];
  endfunction

  // Encryption by exhaustive inversion of the decryptor
  function automatic exp_t mk_exp(input logic m1, input logic [14:0] ad, input logic [7:0] pt);
    exp_t e;
    logic [7:0] c;
    e.m1 = m1; e.ad = ad; e.pt = pt; e.dt = 8'h00; e.err = 1'b0;
    if (int'(sm[mix(m1, ad)]) > 23) begin
      e.err = 1'b1;
    end else begin
      for (int k = 0; k < 256; k++) begin
        c = 8'(k);
        if (ref_dec(m1, ad, c) == pt) e.dt = c;
      end
    end
    return e;
  endfunction

  task automatic tick();
    exp_t e;
    #1;
    accepted = 1'b0;
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("out_unexpected", out_valid, 0);
      end else begin
        e = sb.pop_front();
        check("out_ad", out_ad, e.ad);
        check("out_dt", out_dt, e.dt);
        check("out_err", out_err, e.err);
        if (!e.err) check("roundtrip", ref_dec(e.m1, e.ad, out_dt), e.pt);
      end
    end
    if (in_valid && in_ready) begin
      accepted = 1'b1;
      sb.push_back(mk_exp(in_m1, in_ad, in_dt));
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic load_byte(input logic [24:0] addr, input logic [7:0] data);
    ROMAD = addr; ROMDT = data; ROMEN = 1'b1;
    if (addr[24:7] == 18'h0582) xm[addr[6:0]] = data;
    else if (addr[24:7] == 18'h0583) sm[addr[6:0]] = data;
    tick();
    ROMEN = 1'b0;
  endtask

  task automatic send_chk(input string tag, input logic m1, input logic [14:0] ad,
                          input logic [7:0] dt, input logic [7:0] exp_dt, input logic exp_err);
    in_m1 = m1; in_ad = ad; in_dt = dt; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    check({tag, "_acc"}, accepted, 1);
    in_valid = 1'b0;
    check({tag, "_lat1"}, out_valid, 0);
    tick();
    check({tag, "_lat2"}, out_valid, 1);
    check({tag, "_dt"}, out_dt, exp_dt);
    check({tag, "_err"}, out_err, exp_err);
    tick();
  endtask

  task automatic drain();
    in_valid = 1'b0; out_ready = 1'b1;
    for (int t = 0; t < 12 && sb.size() > 0; t++) tick();
    check("drain_empty", sb.size(), 0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [14:0] bp_ad [4];
    logic [7:0]  bp_dt [4];
    logic [14:0] rad;
    logic        rm1;
    int k;

    reset = 1'b1; ROMEN = 1'b0; ROMAD = '0; ROMDT = '0;
    in_valid = 1'b0; in_m1 = 1'b0; in_ad = '0; in_dt = '0; out_ready = 1'b1;
    @(negedge clk); @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_dt", out_dt, 0);
    check("rst_out_ad", out_ad, 0);
    check("rst_out_err", out_err, 0);
    check("rst_tbl_loaded", tbl_loaded, 0);
    reset = 1'b0;
    #1 check("rst_in_ready", in_ready, 1);
    @(negedge clk);

    for (int i = 0; i < 256; i++) begin
      load_byte(25'h2C100 + 25'(i), 8'h00);
      if (i == 254) check("load_255_not_done", tbl_loaded, 0);
    end
    check("load_256_done", tbl_loaded, 1);

    send_chk("ident", 1'b1, 15'h0, 8'h5A, 8'h5A, 1'b0);

    load_byte(25'h2C180, 8'd1);
    send_chk("swap", 1'b1, 15'h0, 8'h40, 8'h10, 1'b0);
    load_byte(25'h2C100, 8'h55);
    send_chk("swapx", 1'b1, 15'h0, 8'h40, 8'h45, 1'b0);

    load_byte(25'h2C100, 8'h00);
    load_byte(25'h2C180, 8'h00);
    load_byte(25'h2C181, 8'd1);
    load_byte(25'h2C101, 8'h55);
    send_chk("ix_m0", 1'b0, 15'h0, 8'h40, 8'h45, 1'b0);
    send_chk("ix_m1", 1'b1, 15'h0, 8'h40, 8'h40, 1'b0);

    load_byte(25'h2C180, 8'd24);
    send_chk("code24", 1'b1, 15'h0, 8'h40, 8'h00, 1'b1);
    load_byte(25'h2C180, 8'd23);
    send_chk("code23", 1'b1, 15'h0, 8'h40, 8'h01, 1'b0);

    // Backpressure: consumer stalled while four requests are offered
    for (int i = 0; i < 4; i++) begin
      bp_ad[i] = 15'($urandom);
      bp_dt[i] = 8'($urandom);
    end
    out_ready = 1'b0; in_m1 = 1'b1; k = 0;
    for (int t = 0; t < 4 && k < 2; t++) begin
      in_ad = bp_ad[k]; in_dt = bp_dt[k]; in_valid = 1'b1;
      tick();
      if (accepted) k++;
    end
    check("bp_two_acc", k, 2);
    in_ad = bp_ad[2]; in_dt = bp_dt[2];
    #1;
    check("bp_in_ready", in_ready, 0);
    check("bp_valid", out_valid, 1);
    for (int t = 0; t < 3; t++) begin
      tick();
      check("bp_hold_valid", out_valid, 1);
      check("bp_hold_ad", out_ad, sb[0].ad);
      check("bp_hold_dt", out_dt, sb[0].dt);
      check("bp_hold_rdy", in_ready, 0);
    end
    out_ready = 1'b1;
    for (int t = 0; t < 20 && k < 4; t++) begin
      in_ad = bp_ad[k]; in_dt = bp_dt[k]; in_valid = 1'b1;
      tick();
      if (accepted) k++;
    end
    in_valid = 1'b0;
    check("bp_all_acc", k, 4);
    drain();

    // Download interlock
    check("il_pre_loaded", tbl_loaded, 1);
    ROMAD = 25'h0; ROMDT = 8'hFF; ROMEN = 1'b1;
    in_valid = 1'b1; in_ad = 15'($urandom); in_dt = 8'($urandom);
    #1 check("il_in_ready", in_ready, 0);
    tick();
    check("il_no_acc", accepted, 0);
    ROMEN = 1'b0; in_valid = 1'b0;
    check("il_cnt_clr", tbl_loaded, 0);
    #1 check("il_ready_back", in_ready, 1);

    // Reset with two requests in flight
    in_valid = 1'b1; in_ad = 15'($urandom); in_dt = 8'($urandom);
    tick();
    in_ad = 15'($urandom); in_dt = 8'($urandom);
    tick();
    in_valid = 1'b0;
    check("rf_valid_before", out_valid, 1);
    reset = 1'b1;
    #1 check("rf_valid_drop", out_valid, 0);
    sb.delete();
    @(negedge clk);
    reset = 1'b0;
    for (int t = 0; t < 4; t++) tick();
    check("rf_quiet", out_valid, 0);

    // Round trip over random tables and addresses
    for (int i = 0; i < 128; i++) begin
      load_byte(25'h2C100 + 25'(i), 8'($urandom));
      load_byte(25'h2C180 + 25'(i), 8'($urandom_range(0, 23)));
    end
    check("rt_loaded", tbl_loaded, 1);
    for (int a = 0; a < 8; a++) begin
      rad = 15'($urandom);
      rm1 = 1'($urandom);
      for (int p = 0; p < 256; p++) begin
        in_m1 = rm1; in_ad = rad; in_dt = 8'(p); in_valid = 1'b1;
        accepted = 1'b0;
        for (int g = 0; g < 50 && !accepted; g++) begin
          out_ready = ($urandom_range(0, 3) != 0);
          tick();
        end
        if (!accepted) check("rt_accept_timeout", accepted, 1);
      end
      drain();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
